ear_adc_frontend: RTL
=====================

Name: ear_adc_frontend

Overview:
- Samples the LTC2308 ADC over its SPI-like bus at a fixed rate.
- Converts channel 0 into a clean 1-bit tape "ear" level using a hysteresis comparator.
- Flags whether a real tape signal is present.
- Sits directly upstream of the lynx48 core's ear input; the top level gates ear with tape_active.

Parameters:
- CLK_HZ, 50000000, frequency of clock in Hz.
- SAMPLE_HZ, 48000, conversion rate. Period is P = CLK_HZ/SAMPLE_HZ clocks, integer division; 1041 at defaults.
- CONV_CYCLES, 80, clocks to wait after CONVST for conversion (1.6 us).
- SCK_HALF, 2, clocks per SCK half-period.
- HYST_HI, 12'd2200, sample strictly above this sets tape_bit.
- HYST_LO, 12'd1900, sample strictly below this clears tape_bit.
- ACT_WIN, 4096, samples per activity window.
- ACT_MIN, 8, minimum tape_bit toggles per window to declare activity.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- adc_convst  out  1  LTC2308 CONVST.
- adc_sck  out  1  LTC2308 SCK; idles low.
- adc_sdi  out  1  LTC2308 config word, MSB first.
- adc_sdo  in  1  LTC2308 serial data.
- sample  out  12  last converted value, unsigned.
- sample_valid  out  1  one-cycle pulse when sample updates.
- tape_bit  out  1  hysteresis output (ear level).
- tape_active  out  1  tape signal present.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM to IDLE, all counters 0. Reset asserted mid-frame abandons the frame immediately: convst and sck drop low the same cycle. After release, the first CONVST occurs P clocks later.
- Rate counter: free-running 0..P-1. At wrap it issues a start strobe; a strobe is accepted only in IDLE.
- FSM states:
  - IDLE: on start strobe -> CONV. Drive convst=1 for 2 clocks, then 0.
  - CONV: hold for CONV_CYCLES clocks from strobe -> SHIFT.
  - SHIFT: 12 SCK periods of 2*SCK_HALF clocks each, low phase first.
    - sdi presents config 6'b100010 (single-ended, CH0, unipolar, no sleep) during bits 0..5, then 0 for bits 6..11. It changes only while sck is low.
    - adc_sdo is sampled on each SCK rising edge into a shift register, MSB first.
    - After the 12th falling edge -> DONE.
  - DONE: one clock. sample <= shift register, sample_valid=1, hysteresis and activity update -> IDLE.
- Frame length: 2 + (CONV_CYCLES-2) + 12*2*SCK_HALF + 1 = 129 clocks at defaults, which is below P. Elaboration error if frame length >= P.
- Latency: sample_valid fires exactly CONV_CYCLES + 48 + 1 clocks after the CONVST rising edge (129 at defaults).
- Hysteresis, evaluated in DONE only:
  - sample > HYST_HI -> tape_bit=1.
  - sample < HYST_LO -> tape_bit=0.
  - otherwise hold. Values equal to either threshold hold.
- Activity:
  - Toggle counter increments when tape_bit changes in DONE; it saturates at 255.
  - Window counter counts DONE cycles. On the ACT_WIN-th sample: tape_active <= (toggles >= ACT_MIN), then both counters clear.
  - The toggle occurring on the window-closing sample counts toward the closing window.
  - tape_active changes only at window boundaries.
- No sample is dropped or duplicated: exactly one sample_valid per P clocks in steady state.

Decomposition:
- Package ear_adc_pkg: FSM state enum (IDLE, CONV, SHIFT, DONE) and localparam LTC_CFG = 6'b100010.
- Frame-length check helper function also lives in the package.
- Sub-module ltc2308_seq holds the FSM, SCK generation and the shift register. Its outputs are sample and a done pulse.
- Hysteresis and activity logic stay in the top of this block.

Test Plan:
- ADC model returns 12'hABC -> sdi carries 100010 on the first 6 rising edges; sample=12'hABC; sample_valid 129 clocks after CONVST rise; consecutive valids 1041 clocks apart.
- Sample sequence 2000, 2300, 2200, 2000, 1900, 1800 -> tape_bit 0, 1, 1, 1, 1, 0 (holds at the equality boundaries 2200 and 1900).
- Square wave alternating 2500/1500 every 10 samples for 4096 samples -> toggles ≥ 8, tape_active=1 exactly at sample 4096. A constant 2048 for the next window -> tape_active=0 at sample 8192.
- Exactly 7 toggles in a window -> tape_active stays 0. Exactly 8, with the 8th on the closing sample -> tape_active=1.
- reset_n pulsed low mid-SHIFT (bit 5) -> convst, sck, sample_valid, tape_bit, tape_active all 0 asynchronously; no sample_valid for the aborted frame; next CONVST 1041 clocks after release.
- Stuck adc_sdo=1 -> sample=12'hFFF, tape_bit=1 after the first sample, and tape_active=0 at the window boundary.

Source files
------------

// File: rtl/ear_adc_pkg.sv
// Shared types and helpers for the LTC2308 tape-ear front end.
// Holds the sequencer state encoding, the ADC config word and the frame-length helper.
package ear_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Single-ended, CH0, unipolar, no sleep.
    localparam logic [5:0] LTC_CFG = 6'b100010;
    localparam int SAMPLE_BITS = 12;

    function automatic int frame_len(input int conv_cycles, input int sck_half);
        return 2 + (conv_cycles - 2) + SAMPLE_BITS * 2 * sck_half + 1;
    endfunction

    function automatic logic cfg_bit(input logic [3:0] bit_idx);
        logic bit_s;
        if (bit_idx < 4'd6) begin
            bit_s = LTC_CFG[3'd5 - bit_idx[2:0]];
        end else begin
            bit_s = 1'b0;
        end
        return bit_s;
    endfunction

endpackage

// File: rtl/ear_adc_frontend_seq.sv
// LTC2308 conversion sequencer: CONVST pulse, conversion wait, 12-bit SCK burst.
// Emits the captured word and a one-clock done pulse while in DONE.
module ltc2308_seq
    import ear_adc_pkg::*;
#(
    parameter int CONV_CYCLES = 80,
    parameter int SCK_HALF    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        adc_sdo,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    output logic [11:0] sample,
    output logic        done
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int PH_W  = $clog2(SCK_HALF + 1);
    localparam logic [4:0] LAST_HALF = 5'd23;

    seq_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PH_W-1:0]  ph_r;
    logic [4:0]       half_r;
    logic [11:0]      shift_r;
    logic             convst_r;
    logic             sck_r;
    logic             sdi_r;
    logic             done_r;

    logic [4:0]       next_half_s;
    logic             ph_last_s;
    logic             conv_last_s;

    // Next SCK half-period index and end-of-phase decodes.
    always_comb begin
        next_half_s = half_r + 5'd1;
        ph_last_s   = (ph_r == PH_W'(SCK_HALF - 1));
        conv_last_s = (cnt_r == CNT_W'(CONV_CYCLES - 1));
    end

    // Frame sequencer; an odd half-period index means SCK is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            ph_r     <= '0;
            half_r   <= 5'd0;
            shift_r  <= 12'd0;
            convst_r <= 1'b0;
            sck_r    <= 1'b0;
            sdi_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    sck_r <= 1'b0;
                    sdi_r <= 1'b0;
                    if (start) begin
                        state_r  <= CONV;
                        convst_r <= 1'b1;
                        cnt_r    <= '0;
                    end else begin
                        convst_r <= 1'b0;
                    end
                end
                CONV: begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                    convst_r <= (cnt_r == CNT_W'(0));
                    if (conv_last_s) begin
                        state_r <= SHIFT;
                        ph_r    <= '0;
                        half_r  <= 5'd0;
                        sck_r   <= 1'b0;
                        sdi_r   <= cfg_bit(4'd0);
                    end
                end
                SHIFT: begin
                    if (ph_last_s) begin
                        ph_r   <= '0;
                        half_r <= next_half_s;
                        if (half_r == LAST_HALF) begin
                            state_r <= DONE;
                            sck_r   <= 1'b0;
                            sdi_r   <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (next_half_s[0]) begin
                            sck_r   <= 1'b1;
                            shift_r <= {shift_r[10:0], adc_sdo};
                        end else begin
                            sck_r <= 1'b0;
                            sdi_r <= cfg_bit(next_half_s[4:1]);
                        end
                    end else begin
                        ph_r <= ph_r + PH_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign adc_convst = convst_r;
    assign adc_sck    = sck_r;
    assign adc_sdi    = sdi_r;
    assign sample     = shift_r;
    assign done       = done_r;

endmodule

// File: rtl/ear_adc_frontend.sv
// Tape ear front end: periodic LTC2308 sampling, hysteresis slicer and activity detector.
// tape_active is meant to gate tape_bit into the lynx48 core's ear input.
module ear_adc_frontend
    import ear_adc_pkg::*;
#(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          SAMPLE_HZ   = 48_000,
    parameter int          CONV_CYCLES = 80,
    parameter int          SCK_HALF    = 2,
    parameter logic [11:0] HYST_HI     = 12'd2200,
    parameter logic [11:0] HYST_LO     = 12'd1900,
    parameter int          ACT_WIN     = 4096,
    parameter int          ACT_MIN     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        tape_bit,
    output logic        tape_active
);

    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int RATE_W = $clog2(PERIOD);
    localparam int WIN_W  = $clog2(ACT_WIN);

    if (frame_len(CONV_CYCLES, SCK_HALF) >= PERIOD) begin : g_frame_check
        $fatal(1, "ear_adc_frontend: conversion frame does not fit in the sample period");
    end

    logic [RATE_W-1:0] rate_cnt_r;
    logic [11:0]       sample_r;
    logic              sample_valid_r;
    logic              tape_bit_r;
    logic              tape_active_r;
    logic [7:0]        tog_cnt_r;
    logic [WIN_W-1:0]  win_cnt_r;

    logic              start_s;
    logic [11:0]       seq_sample_s;
    logic              seq_done_s;
    logic              tape_next_s;
    logic [7:0]        tog_next_s;
    logic              win_close_s;

    ltc2308_seq #(
        .CONV_CYCLES(CONV_CYCLES),
        .SCK_HALF   (SCK_HALF)
    ) u_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start_s),
        .adc_sdo   (adc_sdo),
        .adc_convst(adc_convst),
        .adc_sck   (adc_sck),
        .adc_sdi   (adc_sdi),
        .sample    (seq_sample_s),
        .done      (seq_done_s)
    );

    // Free-running sample-rate divider.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rate_cnt_r <= '0;
        end else if (rate_cnt_r == RATE_W'(PERIOD - 1)) begin
            rate_cnt_r <= '0;
        end else begin
            rate_cnt_r <= rate_cnt_r + RATE_W'(1);
        end
    end

    // Hysteresis decision and saturating toggle count for the incoming word.
    always_comb begin
        start_s = (rate_cnt_r == RATE_W'(PERIOD - 1));
        if (seq_sample_s > HYST_HI) begin
            tape_next_s = 1'b1;
        end else if (seq_sample_s < HYST_LO) begin
            tape_next_s = 1'b0;
        end else begin
            tape_next_s = tape_bit_r;
        end
        if ((tape_next_s != tape_bit_r) && (tog_cnt_r != 8'd255)) begin
            tog_next_s = tog_cnt_r + 8'd1;
        end else begin
            tog_next_s = tog_cnt_r;
        end
        win_close_s = (win_cnt_r == WIN_W'(ACT_WIN - 1));
    end

    // Sample capture, ear level and windowed activity; the closing sample's toggle counts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_r       <= 12'd0;
            sample_valid_r <= 1'b0;
            tape_bit_r     <= 1'b0;
            tape_active_r  <= 1'b0;
            tog_cnt_r      <= 8'd0;
            win_cnt_r      <= '0;
        end else if (seq_done_s) begin
            sample_r       <= seq_sample_s;
            sample_valid_r <= 1'b1;
            tape_bit_r     <= tape_next_s;
            if (win_close_s) begin
                tape_active_r <= (int'(tog_next_s) >= ACT_MIN);
                tog_cnt_r     <= 8'd0;
                win_cnt_r     <= '0;
            end else begin
                tog_cnt_r <= tog_next_s;
                win_cnt_r <= win_cnt_r + WIN_W'(1);
            end
        end else begin
            sample_valid_r <= 1'b0;
        end
    end

    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign tape_bit     = tape_bit_r;
    assign tape_active  = tape_active_r;

endmodule
